cmd_parser: RTL and testbench
=============================

// Module: cmd_parser
// PURPOSE
// Synthesizable front end that turns the server's ASCII command byte stream into
// component write strobes and the shared tick. It sits directly upstream of the
// airflow, thrusters and solar components.
// Each accepted "b"/"f" line becomes one wr_* transfer. Each "t" toggles tick.
// PARAMETERS
// ID_W   2   width of component id field (00 airflow, 01 thrusters, 10 solar)
// IDX_W  8   width of register index field
// VAL_W  64  width of value field
// PORTS
// clk       in   1      system clock, all state on posedge
// rst       in   1      asynchronous, active-low reset (0 = reset)
// in_valid  in   1      byte available on in_data
// in_data   in   8      ASCII byte
// in_ready  out  1      parser can take a byte; byte consumed when in_valid&in_ready
// wr_valid  out  1      write command pending on wr_*
// wr_ready  in   1      consumer accepts; transfer when wr_valid&wr_ready
// wr_float  out  1      0 = binary write ("b"), 1 = float write ("f")
// wr_id     out  ID_W   target component
// wr_index  out  IDX_W  register index
// wr_value  out  VAL_W  value
// tick      out  1      toggles once per accepted "t"
// err       out  1      one-cycle pulse on malformed line
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; wr_valid=0; wr_* = 0; tick=0; err=0; accumulators 0.
// - in_ready = (state != EMIT), driven combinationally from state; it is 1 while in reset.
// - Line grammar: op SP id SP index SP value LF.
//   - id: 1..ID_W chars of '0'/'1', MSB first.
//   - index: decimal, 1+ digits.
//   - value: binary digits for "b", decimal digits for "f".
// - Separators are exactly one 0x20. CR (0x0D) is ignored everywhere.
// - FSM states: IDLE, SP1, ID, IDX, VAL, EMIT, SKIP.
//   IDLE: 'b'/'f' latch wr_float, clear accumulators -> SP1.
//         't' toggles tick, stays IDLE.
//         LF/SP/CR ignored.
//         'h' -> SKIP (reserved, no err). Any other byte -> err, SKIP.
//   SP1:  SP -> ID; else err.
//   ID:   digit shifts into id. SP with 1..ID_W digits -> IDX.
//         Zero digits, >ID_W digits, non-digit, or id==all-ones -> err.
//   IDX:  idx = idx*10 + d. SP with >=1 digit -> VAL.
//         Result > 2^IDX_W-1 -> err.
//   VAL:  "b": val = {val[VAL_W-2:0], bit}. "f": val = val*10 + d, modulo 2^VAL_W
//         (silent wrap). LF with >=1 digit -> EMIT. Digit not legal for the op -> err.
//   EMIT: wr_valid=1, wr_* stable, no bytes taken. On wr_ready -> IDLE, and wr_valid
//         drops the next cycle.
//   SKIP: discard bytes up to and including LF -> IDLE.
// - "err" always means: err high for exactly the cycle after the offending byte is
//   consumed, partial line discarded, go to SKIP. If the offending byte is LF, go
//   straight to IDLE.
// - Latency: LF consumed in cycle N -> wr_valid high in cycle N+1. tick changes in the
//   cycle after 't' is consumed.
// - Back-to-back: the next line's op byte can be consumed in the cycle after the
//   wr handshake.
// - Reset mid-line or during EMIT: the pending command is dropped and never emitted.
// - wr_ready while wr_valid=0 is ignored.
// TESTING
// - Send "b 00 3 1\n": one transfer, wr_float=0, id=00, index=3, value=1; err never pulses.
// - Send "f 10 1 120\n", hold wr_ready=0 for 5 cycles: wr_valid held, fields stable,
//   in_ready=0; then ready -> single transfer with value=120.
// - Send "t\nt\nt\n": tick toggles 0->1->0->1; no wr_valid.
// - Send "f 11 0 5\n", "x\n", "b 01 300 1\n" (IDX_W=8): three err pulses, no transfers;
//   a following "b 01 3 10\n" emits id=01, index=3, value=2.
// - Send "f 01 2 18446744073709551617\n": value wraps to 1, no err.
// - Drop rst low mid-line "b 00 1" and during EMIT: outputs return to reset values at
//   once; after release, "b 00 5 1\n" emits a correct single transfer.

Source files
------------

// File: rtl/cmd_parser.sv
// ASCII command-line parser: turns "b"/"f" lines into component write transfers
// and "t" bytes into toggles of the shared tick.
module cmd_parser #(
  parameter int ID_W  = 2,
  parameter int IDX_W = 8,
  parameter int VAL_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic             wr_float,
  output logic [ID_W-1:0]  wr_id,
  output logic [IDX_W-1:0] wr_index,
  output logic [VAL_W-1:0] wr_value,
  output logic             tick,
  output logic             err
);

  localparam int CNT_W = $clog2(ID_W + 1);
  localparam logic [CNT_W-1:0] ID_FULL = CNT_W'(ID_W);
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {S_IDLE, S_SP1, S_ID, S_IDX, S_VAL, S_EMIT, S_SKIP} state_t;

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_bin(input logic [7:0] c);
    return (c == 8'h30) || (c == 8'h31);
  endfunction

  // Four bits of headroom: 10*acc+9 always fits, so overflow shows in the top nibble.
  function automatic logic [IDX_W+3:0] idx_mac(input logic [IDX_W-1:0] acc,
                                               input logic [3:0] d);
    logic [IDX_W+3:0] w;
    w = {4'd0, acc};
    return (w << 3) + (w << 1) + {{IDX_W{1'b0}}, d};
  endfunction

  function automatic logic [VAL_W-1:0] val_mac(input logic [VAL_W-1:0] acc,
                                               input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {{(VAL_W-4){1'b0}}, d};
  endfunction

  state_t           state_q, state_d;
  logic             float_q, float_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic             have_q, have_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             take;
  logic             bad;
  logic [3:0]       digit;
  logic [IDX_W+3:0] idx_next;

  assign in_ready = (state_q != S_EMIT);
  assign take     = in_valid && in_ready && (in_data != CH_CR);
  assign digit    = in_data[3:0];
  assign idx_next = idx_mac(idx_q, digit);

  assign wr_valid = (state_q == S_EMIT);
  assign wr_float = float_q;
  assign wr_id    = id_q;
  assign wr_index = idx_q;
  assign wr_value = val_q;
  assign tick     = tick_q;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      float_q <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      have_q  <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      float_q <= float_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      have_q  <= have_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    float_d = float_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    have_d  = have_q;
    tick_d  = tick_q;
    err_d   = 1'b0;
    bad     = 1'b0;

    if (state_q == S_EMIT) begin
      if (wr_ready) state_d = S_IDLE;
    end else if (take) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == "b" || in_data == "f") begin
            float_d = (in_data == "f");
            id_d    = '0;
            cnt_d   = '0;
            idx_d   = '0;
            val_d   = '0;
            have_d  = 1'b0;
            state_d = S_SP1;
          end else if (in_data == "t") begin
            tick_d = ~tick_q;
          end else if (in_data == "h") begin
            state_d = S_SKIP;
          end else if (in_data != CH_LF && in_data != CH_SP) begin
            bad = 1'b1;
          end
        end
        S_SP1: begin
          if (in_data == CH_SP) state_d = S_ID;
          else                  bad = 1'b1;
        end
        S_ID: begin
          if (is_bin(in_data)) begin
            if (cnt_q == ID_FULL) begin
              bad = 1'b1;
            end else begin
              id_d  = ID_W'({id_q, in_data[0]});
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (in_data == CH_SP && cnt_q != '0 && id_q != '1) begin
            state_d = S_IDX;
          end else begin
            bad = 1'b1;
          end
        end
        S_IDX: begin
          if (is_dec(in_data)) begin
            if (idx_next[IDX_W+3:IDX_W] != 4'd0) begin
              bad = 1'b1;
            end else begin
              idx_d  = idx_next[IDX_W-1:0];
              have_d = 1'b1;
            end
          end else if (in_data == CH_SP && have_q) begin
            have_d  = 1'b0;
            state_d = S_VAL;
          end else begin
            bad = 1'b1;
          end
        end
        S_VAL: begin
          if (float_q && is_dec(in_data)) begin
            val_d  = val_mac(val_q, digit);
            have_d = 1'b1;
          end else if (!float_q && is_bin(in_data)) begin
            val_d  = {val_q[VAL_W-2:0], in_data[0]};
            have_d = 1'b1;
          end else if (in_data == CH_LF && have_q) begin
            state_d = S_EMIT;
          end else begin
            bad = 1'b1;
          end
        end
        S_SKIP: begin
          if (in_data == CH_LF) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // A malformed LF already ends the line, so there is nothing left to skip.
      if (bad) begin
        err_d   = 1'b1;
        state_d = (in_data == CH_LF) ? S_IDLE : S_SKIP;
      end
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: a line-level grammar model predicts the ordered
// write/err/tick events, and a per-cycle monitor matches DUT activity against them.
module tb_cmd_parser;
  localparam int ID_W   = 2;
  localparam int IDX_W  = 8;
  localparam int VAL_W  = 64;
  localparam int K_WR   = 0;
  localparam int K_ERR  = 1;
  localparam int K_TICK = 2;

  typedef struct {
    int               kind;
    logic             flt;
    logic [ID_W-1:0]  id;
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] val;
    logic             tk;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             wr_valid;
  logic             wr_ready;
  logic             wr_float;
  logic [ID_W-1:0]  wr_id;
  logic [IDX_W-1:0] wr_index;
  logic [VAL_W-1:0] wr_value;
  logic             tick;
  logic             err;

  int   checks = 0;
  int   passes = 0;
  ev_t  evq[$];
  logic model_tick = 1'b0;
  logic prev_tick  = 1'b0;

  always #5 clk = ~clk;

  cmd_parser #(.ID_W(ID_W), .IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_float(wr_float), .wr_id(wr_id),
    .wr_index(wr_index), .wr_value(wr_value), .tick(tick), .err(err)
  );

  task automatic chk(input string name, input logic [VAL_W-1:0] act, input logic [VAL_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic string next_tok(input string s, inout int i);
    int j;
    j = i;
    while (i < s.len() && s[i] != " ") i++;
    return (i > j) ? s.substr(j, i - 1) : "";
  endfunction

  // Line-level model: what one LF-terminated line must produce, in order.
  task automatic model_line(input string raw);
    string      s;
    string      tok;
    int         i;
    int         v;
    logic       ok;
    logic [7:0] c;
    logic [VAL_W-1:0] w;
    ev_t        e;
    s = "";
    i = 0;
    for (int k = 0; k < raw.len(); k++) if (raw[k] != 8'h0D) s = {s, raw.substr(k, k)};
    e = '{default: 0};
    while (i < s.len() && (s[i] == " " || s[i] == "t")) begin
      if (s[i] == "t") begin
        model_tick = ~model_tick;
        e.kind = K_TICK;
        e.tk   = model_tick;
        evq.push_back(e);
      end
      i++;
    end
    if (i >= s.len() || s[i] == "h") return;
    e.kind = K_ERR;
    if (s[i] != "b" && s[i] != "f") begin
      evq.push_back(e);
      return;
    end
    e.flt = (s[i] == "f");
    i++;
    ok = 1'b1;
    if (i < s.len() && s[i] == " ") i++; else ok = 1'b0;
    tok = next_tok(s, i);
    v = 0;
    if (tok.len() < 1 || tok.len() > ID_W) ok = 1'b0;
    for (int k = 0; k < tok.len(); k++) begin
      c = tok[k];
      if (c == "0" || c == "1") v = v * 2 + ((c == "1") ? 1 : 0);
      else ok = 1'b0;
    end
    if (v == (1 << ID_W) - 1) ok = 1'b0;
    e.id = ID_W'(v);
    if (i < s.len() && s[i] == " ") i++; else ok = 1'b0;
    tok = next_tok(s, i);
    v = 0;
    if (tok.len() < 1) ok = 1'b0;
    for (int k = 0; k < tok.len(); k++) begin
      c = tok[k];
      if (c >= "0" && c <= "9") begin
        if (v <= (1 << IDX_W) - 1) v = v * 10 + int'(c - 8'h30);
      end else ok = 1'b0;
    end
    if (v > (1 << IDX_W) - 1) ok = 1'b0;
    e.idx = IDX_W'(v);
    if (i < s.len() && s[i] == " ") i++; else ok = 1'b0;
    tok = (i < s.len()) ? s.substr(i, s.len() - 1) : "";
    if (tok.len() < 1) ok = 1'b0;
    w = '0;
    for (int k = 0; k < tok.len(); k++) begin
      c = tok[k];
      if (e.flt && c >= "0" && c <= "9") w = w * 64'd10 + VAL_W'(c - 8'h30);
      else if (!e.flt && (c == "0" || c == "1")) w = {w[VAL_W-2:0], (c == "1")};
      else ok = 1'b0;
    end
    e.val = w;
    if (ok) e.kind = K_WR;
    evq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic send_raw(input string s);
    for (int k = 0; k < s.len(); k++) send_byte(s[k]);
  endtask

  task automatic send_line(input string s);
    send_raw(s);
    send_byte(8'h0A);
  endtask

  task automatic line(input string s);
    model_line(s);
    send_line(s);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 60 && evq.size() != 0; g++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({"drain_", tag}, evq.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_valid"}, wr_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_tick"},     tick,     1'b0);
    chk({tag, "_err"},      err,      1'b0);
    chk({tag, "_wr_float"}, wr_float, 1'b0);
    chk({tag, "_wr_id"},    wr_id,    0);
    chk({tag, "_wr_index"}, wr_index, 0);
    chk({tag, "_wr_value"}, wr_value, 0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2;
    in_valid   = 1'b0;
    rst        = 1'b0;
    evq.delete();
    model_tick = 1'b0;
    #1;
    check_reset(tag);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin
    logic exp_e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_tick = tick;
      end else begin
        chk("in_ready_rule", in_ready, !wr_valid);
        if (wr_valid) begin
          if (evq.size() > 0 && evq[0].kind == K_WR) begin
            chk("wr_float", wr_float, evq[0].flt);
            chk("wr_id",    wr_id,    evq[0].id);
            chk("wr_index", wr_index, evq[0].idx);
            chk("wr_value", wr_value, evq[0].val);
            if (wr_ready) void'(evq.pop_front());
          end else begin
            chk("unexpected_wr", wr_valid, 1'b0);
          end
        end
        if (err) begin
          exp_e = (evq.size() > 0 && evq[0].kind == K_ERR);
          chk("err_pulse", err, exp_e);
          if (exp_e) void'(evq.pop_front());
        end
        if (tick !== prev_tick) begin
          if (evq.size() > 0 && evq[0].kind == K_TICK) begin
            chk("tick_value", tick, evq[0].tk);
            void'(evq.pop_front());
          end else begin
            chk("unexpected_tick", tick, prev_tick);
          end
          prev_tick = tick;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    wr_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 check_reset("por");
    @(negedge clk);
    rst = 1'b1;

    // Basic binary write and LF-to-wr_valid latency
    model_line("b 00 3 1");
    chk("pin_t1_kind", evq[$].kind, K_WR);
    chk("pin_t1_idx",  evq[$].idx,  3);
    chk("pin_t1_val",  evq[$].val,  1);
    send_line("b 00 3 1");
    idle();
    chk("lat_wr_valid", wr_valid, 1'b1);
    chk("lat_in_ready", in_ready, 1'b0);
    chk("t1_value",     wr_value, 1);
    drain("t1");

    // Back-pressure: fields must hold while wr_ready is low
    wr_ready = 1'b0;
    line("f 10 1 120");
    idle();
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid",    wr_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_value",    wr_value, 120);
      chk("hold_id",       wr_id,    2);
      chk("hold_index",    wr_index, 1);
      chk("hold_float",    wr_float, 1'b1);
      @(negedge clk);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", wr_valid, 1'b0);
    drain("t2");

    // Tick toggles
    line("t");
    line("t");
    line("t");
    idle();
    drain("t3");
    chk("tick_final", tick, 1'b1);

    // Error lines followed by a good line
    model_line("f 11 0 5");
    chk("pin_err_id11", evq[$].kind, K_ERR);
    send_line("f 11 0 5");
    model_line("x");
    chk("pin_err_x", evq[$].kind, K_ERR);
    send_line("x");
    model_line("b 01 300 1");
    chk("pin_err_idx", evq[$].kind, K_ERR);
    send_line("b 01 300 1");
    model_line("b 01 3 10");
    chk("pin_t4_val", evq[$].val, 2);
    chk("pin_t4_id",  evq[$].id,  1);
    send_line("b 01 3 10");
    idle();
    drain("t4");

    // Decimal wrap modulo 2^64
    model_line("f 01 2 18446744073709551617");
    chk("pin_wrap_kind", evq[$].kind, K_WR);
    chk("pin_wrap_val",  evq[$].val,  1);
    send_line("f 01 2 18446744073709551617");
    idle();
    drain("t5");

    // Boundaries and assorted malformed lines, back to back
    model_line("b 10 255 1111");
    chk("pin_idx255", evq[$].idx, 255);
    send_line("b 10 255 1111");
    model_line("f 00 256 1");
    chk("pin_idx256", evq[$].kind, K_ERR);
    send_line("f 00 256 1");
    line("f 0 0 0");
    line("b 100 1 1");
    line("b 00 3 12");
    line("b 00 3");
    line("h anything 9");
    line("b 01 4 1\r");
    line("");
    line("q");
    line("f 01 7 42");
    idle();
    drain("t6");

    // Reset mid-line, then a clean command
    send_raw("b 00 1");
    idle();
    apply_reset("rst_mid");
    line("b 00 5 1");
    idle();
    drain("t7");

    // Reset while a write is pending
    wr_ready = 1'b0;
    line("b 10 9 101");
    idle();
    chk("pre_rst_emit", wr_valid, 1'b1);
    apply_reset("rst_emit");
    wr_ready = 1'b1;
    line("b 00 5 1");
    idle();
    drain("t8");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
